t07_player_move_ctrl: RTL and testbench
=======================================

Name: t07_player_move_ctrl

Overview:
Sequences updates of the player's grid cell (pos_x, pos_y) that feed the player pixel generator.
- Turns button presses into single-cell moves.
- Asks game logic whether the target cell is blocked, using a valid/ready query handshake.
- Commits an approved move only on a frame-start strobe, so coordinates never change mid-frame.
- Sits between the input synchronizers, the game-logic occupancy map and the pixel generator.

Parameters:
GRID_W, 8, number of columns (2..8)
GRID_H, 8, number of rows (2..8)
START_X, 3, pos_x after reset
START_Y, 3, pos_y after reset
QRY_TIMEOUT, 15, max cycles waiting for query_ready before the move is aborted

Ports:
clk  in  1  system clock
nrst  in  1  reset, asynchronous, active-low
btn_up/btn_down/btn_left/btn_right  in  1 each  synchronized button levels
frame_start  in  1  one-cycle pulse at start of vertical blank
query_valid  out  1  target-cell occupancy request
query_x  out  3  target column
query_y  out  3  target row
query_ready  in  1  game logic answers this cycle
query_blocked  in  1  target occupied, valid with query_ready
pos_x  out  3  current player column, to pixel generator
pos_y  out  3  current player row, to pixel generator
moved  out  1  one-cycle pulse after a commit
bump  out  1  one-cycle pulse when a move is rejected (edge, blocked, timeout)
busy  out  1  high in any state other than IDLE
drop_cnt  out  8  saturating count of presses ignored while busy

Behaviour:
- Reset (async, nrst low):
  - State IDLE; pos_x = START_X, pos_y = START_Y.
  - query_valid, moved, bump, busy and drop_cnt are 0.
  - Button history registers are reset to all-ones, so a button held through reset release produces no move.
- Edge detect:
  - A press is a rising edge: btn high now, history low.
  - History updates every cycle in all states.
  - Simultaneous edges resolve by priority up > down > left > right; the lower-priority edges are discarded and not counted.
- Directions: up = y-1, down = y+1, left = x-1, right = x+1. Coordinates are unsigned 3-bit and never wrap.
- IDLE (busy = 0):
  - Accepted edge with the target off-grid (x=0 left, x=GRID_W-1 right, y=0 up, y=GRID_H-1 down): bump pulses next cycle; stay IDLE.
  - Accepted edge with the target in-grid: latch the target; next cycle enter QUERY with query_valid = 1.
  - frame_start in IDLE is ignored.
- QUERY:
  - query_valid stays high; query_x/query_y hold the latched target and stay stable until the handshake.
  - Handshake occurs when query_valid & query_ready.
  - On handshake with query_blocked = 1: drop query_valid, pulse bump, go to IDLE.
  - On handshake with query_blocked = 0: drop query_valid, go to WAIT_FRAME.
  - Timeout counter: 4-bit, cleared on QUERY entry, increments each cycle without ready. When it reaches QRY_TIMEOUT with no ready, treat as blocked: pulse bump, go to IDLE.
- WAIT_FRAME:
  - On the edge sampling frame_start = 1, pos_x/pos_y load the target.
  - moved pulses the following cycle; state returns to IDLE.
  - Total latency from frame_start to new pos visible: 1 cycle.
- A frame_start coincident with handshake completion is not consumed; the commit waits for the next frame_start.
- Presses while busy:
  - Dropped; each one increments drop_cnt, which saturates at 255.
  - No queuing.
- bump and moved are registered and never high together.
- Reset mid-operation aborts any query and any pending commit; pos returns to START.

Decomposition:
- Package t07_player_pkg holds:
  - dir_t enum {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT}
  - mv_state_t enum {IDLE, QUERY, WAIT_FRAME}
  - grid constants, shared with the pixel generator (cell size 12, pitch 36)
- Sub-module t07_btn_edge: history registers, rising-edge detection and priority encode to dir_t plus a valid pulse.
- The FSM, target arithmetic, timeout counter and drop counter stay in the top module.

Test Plan:
- Reset release with btn_right held, pos (3,3) -> no query_valid in the next 20 cycles; pos stays (3,3).
- Right press; ready=1, blocked=0 on the 3rd QUERY cycle; frame_start 10 cycles later -> query (4,3); pos_x=4 one cycle after the frame_start edge; moved high for exactly 1 cycle.
- From (3,3), down press answered blocked=1 -> bump for 1 cycle, pos unchanged, busy=0 the next cycle.
- From (0,3), left press -> no query_valid; bump for 1 cycle; pos stays (0,3).
- Up press with query_ready never asserted -> query_valid for 15 cycles, then bump; pos unchanged.
- During WAIT_FRAME, 3 presses of left, then 300 more presses -> drop_cnt reads 3, then saturates at 255. Pressing up and left in the same cycle -> only the up target (y-1) is queried.

Source files
------------

// File: rtl/t07_player_pkg.sv
// t07_player_pkg
// Shared types and constants for the player movement path.
//   dir_t       - decoded button direction (DIR_NONE when no press)
//   mv_state_t  - movement controller states
//   target_t    - candidate cell for a move plus an off-grid flag
//   CELL_SIZE / CELL_PITCH - grid geometry also used by the pixel generator
//   next_cell() - computes the neighbouring cell for a direction
package t07_player_pkg;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    QUERY,
    WAIT_FRAME
  } mv_state_t;

  typedef struct packed {
    logic       off;
    logic [2:0] x;
    logic [2:0] y;
  } target_t;

  localparam int COORD_W    = 3;
  localparam int CELL_SIZE  = 12;
  localparam int CELL_PITCH = 36;

  // Neighbouring cell for a direction. Coordinates never wrap: a step
  // past any grid edge only raises the off flag and keeps x/y unchanged.
  function automatic target_t next_cell(input dir_t d, input logic [2:0] x,
                                        input logic [2:0] y, input int gw,
                                        input int gh);
    target_t t;
    t.off = 1'b0;
    t.x   = x;
    t.y   = y;
    case (d)
      DIR_UP: begin
        if (y == 3'd0) t.off = 1'b1;
        else t.y = y - 3'd1;
      end
      DIR_DOWN: begin
        if (int'(y) >= gh - 1) t.off = 1'b1;
        else t.y = y + 3'd1;
      end
      DIR_LEFT: begin
        if (x == 3'd0) t.off = 1'b1;
        else t.x = x - 3'd1;
      end
      DIR_RIGHT: begin
        if (int'(x) >= gw - 1) t.off = 1'b1;
        else t.x = x + 3'd1;
      end
      default: t.off = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/t07_btn_edge.sv
// t07_btn_edge
// Rising-edge detector and priority encoder for the four direction buttons.
//   clk, nrst                    - clock, async active-low reset
//   btn_up/down/left/right       - synchronized button levels
//   dir                          - highest-priority new press (up>down>left>right)
//   dir_valid                    - high in the cycle a new press is seen
module t07_btn_edge
  import t07_player_pkg::*;
(
  input  logic clk,
  input  logic nrst,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  output dir_t dir,
  output logic dir_valid
);

  logic [3:0] btn_now;
  logic [3:0] hist;
  logic [3:0] rise;

  assign btn_now = {btn_up, btn_down, btn_left, btn_right};

  // History resets to all-ones so a button already held when reset is
  // released is treated as old and never produces a press.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) hist <= 4'b1111;
    else       hist <= btn_now;
  end

  assign rise      = btn_now & ~hist;
  assign dir_valid = |rise;

  // Only one direction survives per cycle; lower-priority edges vanish.
  always_comb begin
    dir = DIR_NONE;
    if (rise[3])      dir = DIR_UP;
    else if (rise[2]) dir = DIR_DOWN;
    else if (rise[1]) dir = DIR_LEFT;
    else if (rise[0]) dir = DIR_RIGHT;
  end

endmodule

// File: rtl/t07_player_move_ctrl.sv
// t07_player_move_ctrl
// Converts button presses into single-cell player moves. Each in-grid move
// is checked against game logic with a valid/ready query and is committed
// only on frame_start so the pixel generator never sees a mid-frame change.
//   clk, nrst                        - clock, async active-low reset
//   btn_up/down/left/right           - synchronized button levels
//   frame_start                      - one-cycle vertical-blank strobe
//   query_valid/query_x/query_y      - occupancy request for target cell
//   query_ready/query_blocked        - game logic answer
//   pos_x, pos_y                     - current player cell
//   moved, bump                      - one-cycle commit / reject pulses
//   busy                             - controller not in IDLE
//   drop_cnt                         - saturating count of presses ignored while busy
module t07_player_move_ctrl
  import t07_player_pkg::*;
#(
  parameter int GRID_W      = 8,
  parameter int GRID_H      = 8,
  parameter int START_X     = 3,
  parameter int START_Y     = 3,
  parameter int QRY_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       frame_start,
  output logic       query_valid,
  output logic [2:0] query_x,
  output logic [2:0] query_y,
  input  logic       query_ready,
  input  logic       query_blocked,
  output logic [2:0] pos_x,
  output logic [2:0] pos_y,
  output logic       moved,
  output logic       bump,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  // Last count value before giving up on the query.
  localparam logic [3:0] TIMEOUT_LAST = 4'(QRY_TIMEOUT - 1);

  dir_t      edge_dir;
  logic      edge_valid;
  mv_state_t state;
  logic [3:0] tcnt;
  target_t   nxt;

  t07_btn_edge u_btn_edge (
    .clk       (clk),
    .nrst      (nrst),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .dir       (edge_dir),
    .dir_valid (edge_valid)
  );

  assign nxt = next_cell(edge_dir, pos_x, pos_y, GRID_W, GRID_H);

  // Movement sequencer. query_x/query_y double as the latched target so
  // they stay stable through QUERY and WAIT_FRAME. Ready is honoured ahead
  // of the timeout so an answer on the last allowed cycle still counts.
  // A frame_start arriving with the handshake is not seen here because the
  // commit is only evaluated once the state is WAIT_FRAME.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      pos_x       <= 3'(START_X);
      pos_y       <= 3'(START_Y);
      query_x     <= 3'(START_X);
      query_y     <= 3'(START_Y);
      query_valid <= 1'b0;
      moved       <= 1'b0;
      bump        <= 1'b0;
      busy        <= 1'b0;
      tcnt        <= 4'd0;
    end else begin
      moved <= 1'b0;
      bump  <= 1'b0;
      case (state)
        IDLE: begin
          if (edge_valid) begin
            if (nxt.off) begin
              bump <= 1'b1;
            end else begin
              query_x     <= nxt.x;
              query_y     <= nxt.y;
              query_valid <= 1'b1;
              tcnt        <= 4'd0;
              busy        <= 1'b1;
              state       <= QUERY;
            end
          end
        end
        QUERY: begin
          if (query_valid && query_ready) begin
            query_valid <= 1'b0;
            if (query_blocked) begin
              bump  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= WAIT_FRAME;
            end
          end else if (tcnt == TIMEOUT_LAST) begin
            query_valid <= 1'b0;
            bump        <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            tcnt <= tcnt + 4'd1;
          end
        end
        WAIT_FRAME: begin
          if (frame_start) begin
            pos_x <= query_x;
            pos_y <= query_y;
            moved <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          query_valid <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Presses that arrive while a move is in flight are discarded, not
  // queued; this counter lets the game observe how many were lost.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      drop_cnt <= 8'd0;
    end else if (edge_valid && (state != IDLE) && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_t07_player_move_ctrl.sv
// tb_t07_player_move_ctrl
// Self-checking bench for t07_player_move_ctrl. A move-level reference
// model tracks the player cell and the dropped-press count; each move is
// driven as a directed or randomized transaction and every observable
// output is compared against that model.
module tb_t07_player_move_ctrl;

  localparam int GW = 8;
  localparam int GH = 8;
  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       nrst;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic       frame_start;
  logic       query_valid;
  logic [2:0] query_x, query_y;
  logic       query_ready, query_blocked;
  logic [2:0] pos_x, pos_y;
  logic       moved, bump, busy;
  logic [7:0] drop_cnt;

  int checks = 0;
  int passed = 0;
  int mx, my, mdrop;

  t07_player_move_ctrl #(
    .GRID_W(GW), .GRID_H(GH), .START_X(3), .START_Y(3), .QRY_TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .frame_start  (frame_start),
    .query_valid  (query_valid),
    .query_x      (query_x),
    .query_y      (query_y),
    .query_ready  (query_ready),
    .query_blocked(query_blocked),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .moved        (moved),
    .bump         (bump),
    .busy         (busy),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  // One comparison: counts it and reports tag/observed/expected on a miss.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one clock; outputs are then read 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setBtns(input logic [3:0] m);
    {btn_up, btn_down, btn_left, btn_right} = m;
  endtask

  // Reference rule: up beats down beats left beats right; a step that
  // would leave the grid is rejected rather than wrapped.
  task automatic modelTarget(input logic [3:0] m, input int x, input int y,
                             output int tx, output int ty, output bit off);
    int dx, dy;
    dx = 0;
    dy = 0;
    if (m[3])      dy = -1;
    else if (m[2]) dy = 1;
    else if (m[1]) dx = -1;
    else if (m[0]) dx = 1;
    tx  = x + dx;
    ty  = y + dy;
    off = (tx < 0) || (tx >= GW) || (ty < 0) || (ty >= GH);
  endtask

  task automatic checkPos(input string tag, input int x, input int y);
    checkOutput({tag, "_x"}, pos_x, x);
    checkOutput({tag, "_y"}, pos_y, y);
  endtask

  // One complete move transaction:
  //   mask     buttons pressed together ({up,down,left,right})
  //   rdelay   QUERY cycle (0-based) on which ready is given; >= TO never
  //   blk      answer blocked
  //   coincide frame_start given in the same cycle as the handshake
  //   ndrops   presses made while waiting for the frame
  //   fdelay   idle cycles before the committing frame_start
  task automatic applyStimulus(input logic [3:0] mask, input int rdelay,
                               input bit blk, input bit coincide,
                               input int ndrops, input int fdelay);
    int tx, ty;
    bit off, answered;
    setBtns(4'b0000);
    step();
    modelTarget(mask, mx, my, tx, ty, off);
    setBtns(mask);
    step();
    setBtns(4'b0000);
    if (off) begin
      checkOutput("edge_bump", bump, 1);
      checkOutput("edge_qv", query_valid, 0);
      checkOutput("edge_busy", busy, 0);
      step();
      checkOutput("edge_bump_end", bump, 0);
      checkPos("edge_pos", mx, my);
      return;
    end
    checkOutput("q_valid", query_valid, 1);
    checkOutput("q_x", query_x, tx);
    checkOutput("q_y", query_y, ty);
    checkOutput("q_busy", busy, 1);
    answered = 1'b0;
    for (int c = 0; c < TO; c++) begin
      if (c == rdelay) begin
        query_ready   = 1'b1;
        query_blocked = blk;
        frame_start   = coincide;
        step();
        query_ready   = 1'b0;
        query_blocked = 1'b0;
        frame_start   = 1'b0;
        answered      = 1'b1;
        break;
      end
      step();
      if (c < TO - 1) begin
        checkOutput("q_hold_valid", query_valid, 1);
        checkOutput("q_hold_x", query_x, tx);
        checkOutput("q_hold_y", query_y, ty);
      end
    end
    if (!answered) begin
      checkOutput("to_qv", query_valid, 0);
      checkOutput("to_bump", bump, 1);
      checkOutput("to_busy", busy, 0);
      step();
      checkOutput("to_bump_end", bump, 0);
      checkPos("to_pos", mx, my);
      return;
    end
    checkOutput("hs_qv", query_valid, 0);
    if (blk) begin
      checkOutput("blk_bump", bump, 1);
      checkOutput("blk_moved", moved, 0);
      checkOutput("blk_busy", busy, 0);
      step();
      checkOutput("blk_bump_end", bump, 0);
      checkPos("blk_pos", mx, my);
      return;
    end
    checkOutput("hs_bump", bump, 0);
    checkOutput("hs_busy", busy, 1);
    for (int i = 0; i < ndrops; i++) begin
      btn_left = 1'b1;
      step();
      btn_left = 1'b0;
      step();
      if (mdrop < 255) mdrop++;
    end
    for (int i = 0; i < fdelay; i++) begin
      step();
      checkOutput("wait_moved", moved, 0);
    end
    checkPos("wait_pos", mx, my);
    checkOutput("drop_cnt", drop_cnt, mdrop);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    mx = tx;
    my = ty;
    checkPos("commit_pos", mx, my);
    checkOutput("commit_moved", moved, 1);
    checkOutput("commit_bump", bump, 0);
    checkOutput("commit_busy", busy, 0);
    step();
    checkOutput("moved_end", moved, 0);
  endtask

  initial begin
    nrst          = 1'b0;
    frame_start   = 1'b0;
    query_ready   = 1'b0;
    query_blocked = 1'b0;
    setBtns(4'b0001);
    mx    = 3;
    my    = 3;
    mdrop = 0;

    // Reset values, with btn_right held through reset release.
    step();
    step();
    checkPos("rst_pos", 3, 3);
    checkOutput("rst_qv", query_valid, 0);
    checkOutput("rst_moved", moved, 0);
    checkOutput("rst_bump", bump, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_drop", drop_cnt, 0);
    nrst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checkOutput("held_qv", query_valid, 0);
    end
    checkPos("held_pos", 3, 3);

    // Directed moves.
    applyStimulus(4'b0001, 2, 1'b0, 1'b0, 0, 10);    // right -> (4,3)
    applyStimulus(4'b0010, 0, 1'b0, 1'b0, 0, 1);     // left  -> (3,3)
    applyStimulus(4'b0100, 1, 1'b1, 1'b0, 0, 0);     // down blocked
    applyStimulus(4'b0010, 0, 1'b0, 1'b1, 0, 2);     // left, frame with handshake
    applyStimulus(4'b0010, 3, 1'b0, 1'b0, 0, 0);
    applyStimulus(4'b0010, 14, 1'b0, 1'b0, 0, 0);    // ready on last cycle -> (0,3)
    applyStimulus(4'b0010, 0, 1'b0, 1'b0, 0, 0);     // off left edge
    applyStimulus(4'b1000, 99, 1'b0, 1'b0, 0, 0);    // up, timeout
    applyStimulus(4'b0001, 0, 1'b0, 1'b0, 3, 2);     // drop_cnt 3
    applyStimulus(4'b0001, 0, 1'b0, 1'b0, 300, 0);   // drop_cnt saturates
    applyStimulus(4'b1010, 0, 1'b0, 1'b0, 0, 1);     // up+left -> up only

    // Randomized moves.
    for (int n = 0; n < 40; n++) begin
      applyStimulus(4'($urandom_range(1, 15)), int'($urandom_range(0, 17)),
                    ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
    end

    // Mid-operation reset returns to the start cell.
    setBtns(4'b0001);
    step();
    setBtns(4'b0000);
    nrst = 1'b0;
    #1;
    checkPos("midrst_pos", 3, 3);
    checkOutput("midrst_qv", query_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    step();
    nrst = 1'b1;
    step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
